// File: rtl/adjacency_store.sv
// Per-node linked-list adjacency store: edges are appended during a build phase, then
// neighbour lists are streamed out (most recent first) over a valid/ready interface.
module adjacency_store #(
    parameter int unsigned MAX_NODES         = 1024,
    parameter int unsigned MAX_EDGES         = 2048,
    parameter int unsigned MAX_EDGE_PER_NODE = 32,
    parameter int unsigned NODE_WIDTH        = $clog2(MAX_NODES),
    localparam int unsigned EDGE_PTR_WIDTH   = $clog2(MAX_EDGES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      decoding_done,
    input  logic                      edge_valid,
    input  logic [NODE_WIDTH-1:0]     src_node,
    input  logic [NODE_WIDTH-1:0]     dst_node,
    input  logic [NODE_WIDTH-1:0]     node_idx_cnt,
    input  logic                      query_valid,
    output logic                      query_ready,
    input  logic [NODE_WIDTH-1:0]     query_node,
    output logic                      adj_valid,
    input  logic                      adj_ready,
    output logic [NODE_WIDTH-1:0]     adj_node,
    output logic                      adj_last,
    output logic                      adj_none,
    output logic [EDGE_PTR_WIDTH:0]   edge_count,
    output logic                      edge_overflow,
    output logic                      degree_overflow,
    output logic                      bad_query
);

    localparam int unsigned DEG_WIDTH = $clog2(MAX_EDGE_PER_NODE + 1);

    typedef enum logic [2:0] {BUILD, IDLE, LOOKUP, FETCH, EMIT} state_e;

    state_e                    state_q, state_d;
    logic [EDGE_PTR_WIDTH:0]   edge_count_q, edge_count_d;
    logic                      eovf_q, eovf_d;
    logic                      dovf_q, dovf_d;
    logic                      bq_q, bq_d;
    logic [NODE_WIDTH-1:0]     qnode_q, qnode_d;
    logic                      bad_q, bad_d;
    logic [EDGE_PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic                      none_q, none_d;

    // Edge memory and head pointers carry no reset; validity lives in head_valid_q.
    logic [NODE_WIDTH-1:0]     mem_dst      [MAX_EDGES];
    logic [EDGE_PTR_WIDTH-1:0] mem_next     [MAX_EDGES];
    logic                      mem_next_vld [MAX_EDGES];
    logic [EDGE_PTR_WIDTH-1:0] head_q       [MAX_NODES];
    logic                      head_valid_q [MAX_NODES];
    logic [DEG_WIDTH-1:0]      degree_q     [MAX_NODES];

    logic [NODE_WIDTH-1:0]     rd_dst_q;
    logic [EDGE_PTR_WIDTH-1:0] rd_next_q;
    logic                      rd_next_vld_q;

    logic                      ins_req, edge_full, deg_full, ins_ok;
    logic [DEG_WIDTH-1:0]      src_deg;
    logic [EDGE_PTR_WIDTH-1:0] wr_addr;
    logic                      beat_last;

    always_comb begin
        ins_req   = (state_q == BUILD) && edge_valid;
        src_deg   = degree_q[src_node];
        edge_full = (edge_count_q == (EDGE_PTR_WIDTH + 1)'(MAX_EDGES));
        deg_full  = (src_deg == DEG_WIDTH'(MAX_EDGE_PER_NODE));
        ins_ok    = ins_req && !edge_full && !deg_full;
        wr_addr   = edge_count_q[EDGE_PTR_WIDTH-1:0];
        beat_last = none_q || !rd_next_vld_q;
    end

    always_comb begin
        state_d      = state_q;
        edge_count_d = edge_count_q;
        eovf_d       = eovf_q;
        dovf_d       = dovf_q;
        bq_d         = bq_q;
        qnode_d      = qnode_q;
        bad_d        = bad_q;
        ptr_d        = ptr_q;
        none_d       = none_q;
        unique case (state_q)
            BUILD: begin
                if (ins_req) begin
                    if (edge_full)     eovf_d = 1'b1;
                    else if (deg_full) dovf_d = 1'b1;
                    else               edge_count_d = edge_count_q + 1'b1;
                end
                if (decoding_done) state_d = IDLE;
            end
            IDLE: begin
                if (query_valid) begin
                    qnode_d = query_node;
                    bad_d   = (query_node >= node_idx_cnt);
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bad_q || !head_valid_q[qnode_q]) begin
                    bq_d    = bq_q | bad_q;
                    none_d  = 1'b1;
                    state_d = EMIT;
                end else begin
                    none_d  = 1'b0;
                    ptr_d   = head_q[qnode_q];
                    state_d = FETCH;
                end
            end
            FETCH: state_d = EMIT;
            EMIT: begin
                if (adj_ready) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = rd_next_q;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = BUILD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BUILD;
            edge_count_q <= '0;
            eovf_q       <= 1'b0;
            dovf_q       <= 1'b0;
            bq_q         <= 1'b0;
            qnode_q      <= '0;
            bad_q        <= 1'b0;
            ptr_q        <= '0;
            none_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_count_q <= edge_count_d;
            eovf_q       <= eovf_d;
            dovf_q       <= dovf_d;
            bq_q         <= bq_d;
            qnode_q      <= qnode_d;
            bad_q        <= bad_d;
            ptr_q        <= ptr_d;
            none_q       <= none_d;
        end
    end

    // Per-node bookkeeping; updating flops directly makes same-src back-to-back edges chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_NODES); i++) begin
                head_valid_q[i] <= 1'b0;
                degree_q[i]     <= '0;
            end
        end else if (ins_ok) begin
            head_valid_q[src_node] <= 1'b1;
            degree_q[src_node]     <= src_deg + DEG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ins_ok) begin
            mem_dst[wr_addr]      <= dst_node;
            mem_next[wr_addr]     <= head_q[src_node];
            mem_next_vld[wr_addr] <= head_valid_q[src_node];
            head_q[src_node]      <= wr_addr;
        end
        if (state_q == FETCH) begin
            rd_dst_q      <= mem_dst[ptr_q];
            rd_next_q     <= mem_next[ptr_q];
            rd_next_vld_q <= mem_next_vld[ptr_q];
        end
    end

    always_comb begin
        query_ready     = (state_q == IDLE);
        adj_valid       = (state_q == EMIT);
        adj_none        = adj_valid && none_q;
        adj_last        = adj_valid && beat_last;
        adj_node        = (adj_valid && !none_q) ? rd_dst_q : '0;
        edge_count      = edge_count_q;
        edge_overflow   = eovf_q;
        degree_overflow = dovf_q;
        bad_query       = bq_q;
    end

endmodule

// File: tb/tb_adjacency_store.sv
// Drives two differently-sized adjacency stores with the same stimulus and checks each
// against an edge-list reference model.
module tb_adjacency_store;

    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          decoding_done = 1'b0, edge_valid = 1'b0, query_valid = 1'b0, adj_ready = 1'b1;
    logic [NW-1:0] src_node = '0, dst_node = '0, query_node = '0, node_idx_cnt = 4'd10;

    logic          qr [2], av [2], al [2], an [2], eo [2], dof [2], bq [2];
    logic [NW-1:0] anode [2];
    logic [6:0]    ec [2];
    logic [6:0]    m_ec;
    logic [2:0]    s_ec;
    assign ec[0] = m_ec;
    assign ec[1] = {4'b0, s_ec};

    adjacency_store #(.MAX_NODES(16), .MAX_EDGES(64), .MAX_EDGE_PER_NODE(8)) dut_m (
        .clk(clk), .rst(rst), .decoding_done(decoding_done), .edge_valid(edge_valid),
        .src_node(src_node), .dst_node(dst_node), .node_idx_cnt(node_idx_cnt),
        .query_valid(query_valid), .query_ready(qr[0]), .query_node(query_node),
        .adj_valid(av[0]), .adj_ready(adj_ready), .adj_node(anode[0]), .adj_last(al[0]),
        .adj_none(an[0]), .edge_count(m_ec), .edge_overflow(eo[0]),
        .degree_overflow(dof[0]), .bad_query(bq[0]));

    adjacency_store #(.MAX_NODES(16), .MAX_EDGES(4), .MAX_EDGE_PER_NODE(2)) dut_s (
        .clk(clk), .rst(rst), .decoding_done(decoding_done), .edge_valid(edge_valid),
        .src_node(src_node), .dst_node(dst_node), .node_idx_cnt(node_idx_cnt),
        .query_valid(query_valid), .query_ready(qr[1]), .query_node(query_node),
        .adj_valid(av[1]), .adj_ready(adj_ready), .adj_node(anode[1]), .adj_last(al[1]),
        .adj_none(an[1]), .edge_count(s_ec), .edge_overflow(eo[1]),
        .degree_overflow(dof[1]), .bad_query(bq[1]));

    // Reference model: flat list of accepted edges per DUT, plus sticky flags.
    int e_src [2][64];
    int e_dst [2][64];
    int mcnt [2];
    bit meo [2], mdo [2], mbq [2];
    int max_e [2] = '{64, 4};
    int max_d [2] = '{8, 2};
    bit building;

    int passed = 0, total = 0, failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; meo[d] = 0; mdo[d] = 0; mbq[d] = 0;
        end
        building = 1;
    endtask

    task automatic model_insert(input int s, input int t);
        for (int d = 0; d < 2; d++) begin
            int deg = 0;
            for (int i = 0; i < mcnt[d]; i++) if (e_src[d][i] == s) deg++;
            if (mcnt[d] == max_e[d]) meo[d] = 1;
            else if (deg == max_d[d]) mdo[d] = 1;
            else begin
                e_src[d][mcnt[d]] = s;
                e_dst[d][mcnt[d]] = t;
                mcnt[d]++;
            end
        end
    endtask

    task automatic send_edge(input int s, input int t, input bit done);
        @(negedge clk);
        edge_valid = 1; src_node = NW'(s); dst_node = NW'(t); decoding_done = done;
        if (building) model_insert(s, t);
        if (done) building = 0;
    endtask

    task automatic idle_inputs(input bit done);
        @(negedge clk);
        edge_valid = 0; decoding_done = done;
        if (done) building = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; edge_valid = 0; decoding_done = 0; query_valid = 0; adj_ready = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic check_status(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_edge_count%0d", tag, d), 32'(ec[d]), 32'(mcnt[d]));
            chk($sformatf("%s_edge_ovf%0d", tag, d), 32'(eo[d]), 32'(meo[d]));
            chk($sformatf("%s_deg_ovf%0d", tag, d), 32'(dof[d]), 32'(mdo[d]));
            chk($sformatf("%s_bad_query%0d", tag, d), 32'(bq[d]), 32'(mbq[d]));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_qready%0d", tag, d), 32'(qr[d]), 0);
            chk($sformatf("%s_avalid%0d", tag, d), 32'(av[d]), 0);
            chk($sformatf("%s_alast%0d", tag, d), 32'(al[d]), 0);
            chk($sformatf("%s_anone%0d", tag, d), 32'(an[d]), 0);
            chk($sformatf("%s_anode%0d", tag, d), 32'(anode[d]), 0);
        end
        check_status(tag);
    endtask

    task automatic query(input int n, input bit rnd);
        int  exp_node [2][64];
        bit  exp_none [2];
        int  exp_n [2];
        int  obs_node [2][64];
        bit  obs_last [2][64];
        bit  obs_none [2][64];
        int  obs_n [2];
        int  first [2];
        bit  done [2], held [2];
        logic [NW-1:0] h_node [2];
        logic h_last [2], h_none [2];
        string tag;
        tag = $sformatf("q%0d", n);
        for (int d = 0; d < 2; d++) begin
            exp_n[d] = 0; exp_none[d] = 0;
            if (n >= int'(node_idx_cnt)) mbq[d] = 1;
            else
                for (int i = mcnt[d] - 1; i >= 0; i--)
                    if (e_src[d][i] == n) exp_node[d][exp_n[d]++] = e_dst[d][i];
            if (exp_n[d] == 0) begin
                exp_none[d] = 1; exp_node[d][0] = 0; exp_n[d] = 1;
            end
            obs_n[d] = 0; first[d] = -1; done[d] = 0; held[d] = 0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("%s_ready%0d", tag, d), 32'(qr[d]), 1);
        query_valid = 1; query_node = NW'(n);
        @(negedge clk);
        query_valid = 0;
        for (int k = 1; k <= 300; k++) begin
            adj_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (done[d]) continue;
                if (held[d]) begin
                    chk($sformatf("%s_stall_valid%0d", tag, d), 32'(av[d]), 1);
                    chk($sformatf("%s_stall_node%0d", tag, d), 32'(anode[d]), 32'(h_node[d]));
                    chk($sformatf("%s_stall_last%0d", tag, d), 32'(al[d]), 32'(h_last[d]));
                    chk($sformatf("%s_stall_none%0d", tag, d), 32'(an[d]), 32'(h_none[d]));
                end
                held[d] = 0;
                if (av[d]) begin
                    if (first[d] < 0) first[d] = k;
                    if (adj_ready) begin
                        if (obs_n[d] < 64) begin
                            obs_node[d][obs_n[d]] = int'(anode[d]);
                            obs_last[d][obs_n[d]] = al[d];
                            obs_none[d][obs_n[d]] = an[d];
                        end
                        obs_n[d]++;
                        if (al[d]) done[d] = 1;
                    end else begin
                        held[d] = 1; h_node[d] = anode[d]; h_last[d] = al[d]; h_none[d] = an[d];
                    end
                end
            end
            if (done[0] && done[1]) break;
            @(negedge clk);
        end
        adj_ready = 1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_completed%0d", tag, d), 32'(done[d]), 1);
            chk($sformatf("%s_latency%0d", tag, d), 32'(first[d]), exp_none[d] ? 2 : 3);
            chk($sformatf("%s_beats%0d", tag, d), 32'(obs_n[d]), 32'(exp_n[d]));
            for (int i = 0; i < exp_n[d] && i < obs_n[d]; i++) begin
                chk($sformatf("%s_node%0d_%0d", tag, d, i), 32'(obs_node[d][i]),
                    32'(exp_node[d][i]));
                chk($sformatf("%s_last%0d_%0d", tag, d, i), 32'(obs_last[d][i]),
                    32'(i == exp_n[d] - 1));
                chk($sformatf("%s_none%0d_%0d", tag, d, i), 32'(obs_none[d][i]),
                    32'(exp_none[d]));
            end
        end
        @(negedge clk);
        check_status(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 0;

        // Back-to-back same-source chain plus random traffic on nodes 5..9.
        send_edge(3, 5, 0);
        send_edge(3, 7, 0);
        send_edge(3, 9, 0);
        for (int i = 0; i < 6; i++) send_edge($urandom_range(5, 9), $urandom_range(0, 15), 0);
        send_edge(2, 11, 1);
        send_edge(2, 13, 0);
        idle_inputs(0);
        @(negedge clk);
        check_status("build");

        query(3, 0);
        query(4, 0);
        query(12, 0);
        query(2, 0);
        query(3, 1);
        for (int i = 0; i < 3; i++) query($urandom_range(5, 9), 1);

        // Reset while a beat is presented and stalled.
        @(negedge clk);
        query_valid = 1; query_node = 4'd3;
        @(negedge clk);
        query_valid = 0; adj_ready = 0;
        for (int k = 0; k < 10 && !av[0]; k++) @(negedge clk);
        chk("emit_reached", 32'(av[0]), 1);
        #2 rst = 1;
        #1;
        model_reset();
        check_reset("mid_emit_rst");
        @(negedge clk);
        rst = 0; adj_ready = 1;
        idle_inputs(1);
        idle_inputs(0);
        query(3, 0);

        // Five distinct edges: the small store overflows on the fifth.
        do_reset();
        send_edge(0, 1, 0);
        send_edge(1, 2, 0);
        send_edge(2, 3, 0);
        send_edge(0, 4, 0);
        send_edge(1, 5, 1);
        idle_inputs(0);
        @(negedge clk);
        check_status("edge_ovf");
        query(1, 0);
        query(0, 1);

        // Three edges from one node: the small store hits its degree limit.
        do_reset();
        send_edge(1, 2, 0);
        send_edge(1, 3, 0);
        send_edge(1, 4, 0);
        idle_inputs(1);
        idle_inputs(0);
        @(negedge clk);
        check_status("deg_ovf");
        query(1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
